// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction-fetch sequencer
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2,
      ADV   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - memory-response timeout down-counter, used only when FETCH_TIMEOUT_EN is defined
module fetch_timer #(
   parameter int unsigned CYCLES = 64
) (
   input  logic CLK,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] count;

   // Reloaded while clr is high so the first enabled cycle sees the full budget.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (clr) begin
         count <= 16'(CYCLES);
      end else if (en && count != 16'd0) begin
         count <= count - 16'd1;
      end
   end

   assign expired = en && (count == 16'd1);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch sequencer between PC and a req/ack instruction memory
// Optional memory timeout and sticky fault flag are enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [XLEN-1:0] curPC,
   input  logic            fetchEn,
   output logic            memReq,
   output logic [XLEN-1:0] memAddr,
   input  logic            memAck,
   input  logic [XLEN-1:0] memRData,
   output logic [XLEN-1:0] instr,
   output logic            instrValid,
   input  logic            instrTaken,
   output logic            pcWre,
   output logic            misalign,
   output logic            fault
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT_CYCLES must be within 1..65535");
   end

   fetch_state_t    state, state_d;
   logic            req_d, valid_d, pcwre_d, mis_d;
   logic [XLEN-1:0] addr_d, instr_d;
   logic            tmr_expired;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      req_d   = 1'b0;
      addr_d  = memAddr;
      instr_d = instr;
      valid_d = instrValid;
      pcwre_d = 1'b0;
      mis_d   = misalign;
      case (state)
         IDLE: begin
            // A sticky error parks the sequencer until reset.
            if (fetchEn && !misalign && !fault) begin
               if ((curPC[1:0] & ALIGN_MASK) != 2'b00) begin
                  mis_d = 1'b1;
               end else begin
                  addr_d  = curPC;
                  req_d   = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (memAck) begin
               instr_d = memRData;
               valid_d = 1'b1;
               state_d = VALID;
            end else if (tmr_expired) begin
               state_d = IDLE;
            end else begin
               req_d = 1'b1;
            end
         end
         VALID: begin
            if (instrTaken) begin
               valid_d = 1'b0;
               pcwre_d = 1'b1;
               state_d = ADV;
            end
         end
         ADV: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         memReq     <= 1'b0;
         memAddr    <= '0;
         instr      <= '0;
         instrValid <= 1'b0;
         pcWre      <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         memReq     <= req_d;
         memAddr    <= addr_d;
         instr      <= instr_d;
         instrValid <= valid_d;
         pcWre      <= pcwre_d;
         misalign   <= mis_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   logic fault_q;

   fetch_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .CLK     (CLK),
      .Reset   (Reset),
      .clr     (state == IDLE),
      .en      (state == REQ && !memAck),
      .expired (tmr_expired)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         fault_q <= 1'b0;
      end else if (tmr_expired) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign tmr_expired = 1'b0;
   assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized wait/stall traffic
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] curPC;
   logic        fetchEn;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memRData;
   logic [31:0] instr;
   logic        instrValid;
   logic        instrTaken;
   logic        pcWre;
   logic        misalign;
   logic        fault;

   fetch_unit #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .curPC      (curPC),
      .fetchEn    (fetchEn),
      .memReq     (memReq),
      .memAddr    (memAddr),
      .memAck     (memAck),
      .memRData   (memRData),
      .instr      (instr),
      .instrValid (instrValid),
      .instrTaken (instrTaken),
      .pcWre      (pcWre),
      .misalign   (misalign),
      .fault      (fault)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          w;
      int          s;
      int          issue;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
   endtask

   // Called at a negedge with the DUT idle; w = memAck wait cycles, s = decode stall cycles.
   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int w, input int s);
      exp_t e;
      e.pc = pc; e.data = data; e.w = w; e.s = s; e.issue = cyc;
      exp_q.push_back(e);
      fetchEn = 1'b1; curPC = pc;
      memAck = 1'($urandom); instrTaken = 1'($urandom); memRData = $urandom;
      @(negedge CLK);
      for (int k = 0; k <= w; k++) begin
         fetchEn    = 1'($urandom);
         curPC      = $urandom;
         memAck     = (k == w);
         memRData   = (k == w) ? data : $urandom;
         instrTaken = 1'($urandom);
         @(negedge CLK);
      end
      for (int k = 0; k <= s; k++) begin
         fetchEn    = 1'($urandom);
         memAck     = 1'($urandom);
         memRData   = $urandom;
         instrTaken = (k == s);
         @(negedge CLK);
      end
      fetchEn = 1'($urandom); memAck = 1'($urandom); instrTaken = 1'($urandom);
      @(negedge CLK);
      fetchEn = 1'b0;
   endtask

   // Monitor: accumulates handshake lengths and checks each completed fetch at its pcWre pulse.
   initial begin
      exp_t e;
      int   req_cnt;
      int   val_cnt;
      logic prev_pcwre;
      req_cnt = 0; val_cnt = 0; prev_pcwre = 1'b0;
      forever begin
         @(negedge CLK);
         if (!Reset) begin
            req_cnt = 0; val_cnt = 0; prev_pcwre = 1'b0;
         end else begin
            if (memReq) req_cnt++;
            if (instrValid) val_cnt++;
            if (pcWre) begin
               chk_b("pcwre_single_cycle", prev_pcwre, 1'b0);
               chk_b("pcwre_with_valid", instrValid, 1'b0);
               if (exp_q.size() == 0) begin
                  chk_b("unexpected_pcwre", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("memaddr", memAddr, e.pc);
                  chk("instr", instr, e.data);
                  chk("memreq_cycles", req_cnt, e.w + 1);
                  chk("valid_cycles", val_cnt, e.s + 1);
                  chk("pcwre_latency", cyc - e.issue, 3 + e.w + e.s);
               end
               req_cnt = 0; val_cnt = 0;
            end
            prev_pcwre = pcWre;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] pc;
      int          w, s, n;

      Reset = 1'b0; fetchEn = 1'b1; memAck = 1'b1; curPC = 32'h40;
      instrTaken = 1'b1; memRData = $urandom;
      repeat (3) @(negedge CLK);
      chk_b("rst_memreq", memReq, 1'b0);
      chk("rst_memaddr", memAddr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk_b("rst_valid", instrValid, 1'b0);
      chk_b("rst_pcwre", pcWre, 1'b0);
      chk_b("rst_misalign", misalign, 1'b0);
      chk_b("rst_fault", fault, 1'b0);

      Reset = 1'b1;
      @(negedge CLK);
      chk_b("first_req_after_reset", memReq, 1'b1);
      chk("first_req_addr", memAddr, 32'h40);
      #2 Reset = 1'b0;
      #1 chk_b("reset_mid_req_memreq", memReq, 1'b0);
      chk_b("reset_mid_req_pcwre", pcWre, 1'b0);
      fetchEn = 1'b0;
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);

      do_fetch(32'h0000_0010, 32'h2001_0005, 0, 0);
`ifdef FETCH_TIMEOUT_EN
      do_fetch(32'h0000_0020, 32'hDEAD_BEEF, 3, 3);
`else
      do_fetch(32'h0000_0020, 32'hDEAD_BEEF, 5, 3);
`endif

      for (int i = 0; i < 40; i++) begin
         pc = $urandom; pc[1:0] = 2'b00;
`ifdef FETCH_TIMEOUT_EN
         w = $urandom_range(0, 3);
`else
         w = $urandom_range(0, 6);
`endif
         s = $urandom_range(0, 3);
         do_fetch(pc, $urandom, w, s);
         n = $urandom_range(0, 2);
         repeat (n) begin
            curPC = $urandom; memAck = 1'($urandom); instrTaken = 1'($urandom);
            @(negedge CLK);
         end
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
      chk("queue_drained", exp_q.size(), 0);

      fetchEn = 1'b1; curPC = 32'h0000_0006; memAck = 1'b0; instrTaken = 1'b0;
      @(negedge CLK);
      chk_b("misalign_set", misalign, 1'b1);
      chk_b("misalign_no_req", memReq, 1'b0);
      curPC = 32'h0000_0100;
      repeat (4) begin
         @(negedge CLK);
         chk_b("misalign_blocks_fetch", memReq, 1'b0);
      end
      fetchEn = 1'b0; Reset = 1'b0;
      @(negedge CLK);
      chk_b("misalign_cleared", misalign, 1'b0);
      Reset = 1'b1;

      fetchEn = 1'b1; curPC = 32'h0000_0080;
      @(negedge CLK);
      fetchEn = 1'b0; memAck = 1'b1; memRData = 32'h1234_5678;
      @(negedge CLK);
      memAck = 1'b0;
      chk_b("mid_valid_set", instrValid, 1'b1);
      #2 Reset = 1'b0;
      #1 chk_b("reset_mid_valid", instrValid, 1'b0);
      chk_b("reset_mid_valid_pcwre", pcWre, 1'b0);
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);

`ifdef FETCH_TIMEOUT_EN
      fetchEn = 1'b1; curPC = 32'h0000_0200; memAck = 1'b0;
      @(negedge CLK);
      fetchEn = 1'b0;
      n = 0;
      repeat (8) begin
         if (memReq) n++;
         @(negedge CLK);
      end
      chk("timeout_req_cycles", n, 4);
      chk_b("timeout_fault", fault, 1'b1);
      chk_b("timeout_no_valid", instrValid, 1'b0);
      fetchEn = 1'b1; curPC = 32'h0000_0300;
      repeat (3) begin
         @(negedge CLK);
         chk_b("fault_blocks_fetch", memReq, 1'b0);
      end
      fetchEn = 1'b0; Reset = 1'b0;
      @(negedge CLK);
      chk_b("fault_cleared", fault, 1'b0);
      Reset = 1'b1;
      @(negedge CLK);
`else
      chk_b("fault_tied_low", fault, 1'b0);
`endif

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
